// File: rtl/gpio_irq_pkg.sv
// rtl/gpio_irq_pkg.sv - shared GPIO register select codes, pin count and register map types.
`ifndef GPIO_IRQ_DEFS_SVH
`define GPIO_IRQ_DEFS_SVH
`define GPIO_N_PINS      16
`define GPIO_SEL_IRQEN   3'b000
`define GPIO_SEL_IRQRISE 3'b001
`define GPIO_SEL_IRQFALL 3'b010
`define GPIO_SEL_IRQPEND 3'b011
`define GPIO_SEL_LEVEL   3'b100
`endif

package gpio_irq_pkg;

  localparam int N_PINS = `GPIO_N_PINS;

  typedef enum logic [2:0] {
    SEL_IRQEN   = `GPIO_SEL_IRQEN,
    SEL_IRQRISE = `GPIO_SEL_IRQRISE,
    SEL_IRQFALL = `GPIO_SEL_IRQFALL,
    SEL_IRQPEND = `GPIO_SEL_IRQPEND,
    SEL_LEVEL   = `GPIO_SEL_LEVEL
  } reg_sel_e;

endpackage

// File: rtl/gpio_debounce.sv
// rtl/gpio_debounce.sv - one-pin two-flop synchronizer with a stable-count debounce filter.
module gpio_debounce #(
  parameter int DB_CYCLES = 4,
  parameter int CNT_W     = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic pin_in,
  output logic filt,
  output logic filt_next
);

  logic             s1;
  logic             s2;
  logic [CNT_W-1:0] cnt;
  logic             cnt_done;

  assign cnt_done = (cnt == CNT_W'(DB_CYCLES - 1));

  // filt_next feeds the edge detector in the same cycle filt updates
  always_comb begin
    filt_next = filt;
    if ((s2 != filt) && cnt_done) begin
      filt_next = s2;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1   <= 1'b0;
      s2   <= 1'b0;
      filt <= 1'b0;
      cnt  <= '0;
    end else begin
      s1   <= pin_in;
      s2   <= s1;
      filt <= filt_next;
      if ((s2 == filt) || cnt_done) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/gpio_irq.sv
// rtl/gpio_irq.sv - GPIO input conditioning, edge-triggered pending flags and level interrupt.
module gpio_irq
  import gpio_irq_pkg::*;
#(
  parameter int DB_CYCLES = 4,
  parameter int CNT_W     = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  regSel,
  input  logic        we,
  input  logic [31:0] di,
  output logic [31:0] dout,
  input  logic [15:0] pins_in,
  output logic [15:0] level,
  output logic        irq
);

  logic [N_PINS-1:0] filt;
  logic [N_PINS-1:0] filt_next;
  logic [N_PINS-1:0] irq_en;
  logic [N_PINS-1:0] irq_rise;
  logic [N_PINS-1:0] irq_fall;
  logic [N_PINS-1:0] irq_pend;
  logic [N_PINS-1:0] pend_set;
  logic [N_PINS-1:0] pend_clr;
  reg_sel_e          sel;
  logic              unused_di;

  assign sel       = reg_sel_e'(regSel);
  assign unused_di = ^di[31:16];

  for (genvar i = 0; i < N_PINS; i++) begin : g_pin
    gpio_debounce #(
      .DB_CYCLES(DB_CYCLES),
      .CNT_W    (CNT_W)
    ) u_debounce (
      .clk      (clk),
      .reset    (reset),
      .pin_in   (pins_in[i]),
      .filt     (filt[i]),
      .filt_next(filt_next[i])
    );
  end

  assign pend_set = (~filt & filt_next & irq_rise) | (filt & ~filt_next & irq_fall);
  assign pend_clr = (we && sel == SEL_IRQPEND) ? di[N_PINS-1:0] : '0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      irq_en   <= '0;
      irq_rise <= '0;
      irq_fall <= '0;
      irq_pend <= '0;
    end else begin
      if (we && sel == SEL_IRQEN)   irq_en   <= di[N_PINS-1:0];
      if (we && sel == SEL_IRQRISE) irq_rise <= di[N_PINS-1:0];
      if (we && sel == SEL_IRQFALL) irq_fall <= di[N_PINS-1:0];
      // a hardware set outranks a same-cycle write-one-to-clear
      irq_pend <= (irq_pend & ~pend_clr) | pend_set;
    end
  end

  always_comb begin
    dout = '0;
    case (sel)
      SEL_IRQEN:   dout[N_PINS-1:0] = irq_en;
      SEL_IRQRISE: dout[N_PINS-1:0] = irq_rise;
      SEL_IRQFALL: dout[N_PINS-1:0] = irq_fall;
      SEL_IRQPEND: dout[N_PINS-1:0] = irq_pend;
      SEL_LEVEL:   dout[N_PINS-1:0] = filt;
      default:     dout = '0;
    endcase
  end

  assign level = filt;
  assign irq   = |(irq_pend & irq_en);

endmodule

// File: tb/tb_gpio_irq.sv
// tb/tb_gpio_irq.sv - directed-vector bench for gpio_irq.
module tb_gpio_irq;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [2:0]  regSel = 3'd0;
  logic        we = 1'b0;
  logic [31:0] di = 32'd0;
  logic [31:0] dout;
  logic [15:0] pins_in = 16'h0000;
  logic [15:0] level;
  logic        irq;

  int n_vec = 0;
  int n_bad = 0;

  gpio_irq #(.DB_CYCLES(4), .CNT_W(8)) dut (
    .clk    (clk),
    .reset  (reset),
    .regSel (regSel),
    .we     (we),
    .di     (di),
    .dout   (dout),
    .pins_in(pins_in),
    .level  (level),
    .irq    (irq)
  );

  always #5 clk = ~clk;

  task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic reg_wr(input logic [2:0] a, input logic [31:0] d);
    @(negedge clk);
    regSel = a;
    di     = d;
    we     = 1'b1;
    @(posedge clk);
    #1;
    we = 1'b0;
    di = 32'd0;
  endtask

  task automatic reg_chk(input string tag, input logic [2:0] a, input logic [31:0] exp);
    @(negedge clk);
    regSel = a;
    #1;
    check_vec(tag, dout, exp);
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    // reset held with all pins high
    pins_in = 16'hFFFF;
    repeat (3) @(posedge clk);
    for (int s = 0; s < 8; s++) begin
      regSel = 3'(s);
      #1;
      check_vec($sformatf("rst_do_sel%0d", s), dout, 32'h0);
    end
    check_vec("rst_irq", {31'd0, irq}, 32'h0);
    check_vec("rst_level", {16'd0, level}, 32'h0);
    @(negedge clk);
    reset = 1'b1;
    wait_cycles(10);
    reg_chk("post_rst_level", 3'b100, 32'h0000_FFFF);
    reg_chk("post_rst_pend", 3'b011, 32'h0);

    // drop all pins back to 0, no edges enabled
    pins_in = 16'h0000;
    wait_cycles(10);
    reg_chk("idle_low_level", 3'b100, 32'h0);
    reg_chk("idle_low_pend", 3'b011, 32'h0);

    // rising-edge latency: pend at N+5, not N+4
    reg_wr(3'b001, 32'h0001);
    reg_wr(3'b000, 32'h0001);
    @(negedge clk);
    pins_in[0] = 1'b1;
    regSel = 3'b011;
    repeat (5) @(posedge clk);
    #1;
    check_vec("rise_pend_n4", dout, 32'h0);
    check_vec("rise_irq_n4", {31'd0, irq}, 32'h0);
    @(posedge clk);
    #1;
    check_vec("rise_pend_n5", dout, 32'h0001);
    check_vec("rise_irq_n5", {31'd0, irq}, 32'h1);
    reg_wr(3'b011, 32'h0001);
    reg_chk("rise_cleared", 3'b011, 32'h0);
    check_vec("rise_irq_cleared", {31'd0, irq}, 32'h0);
    reg_wr(3'b000, 32'h0000);

    // glitch rejection on pin 3
    reg_wr(3'b001, 32'h0008);
    @(negedge clk);
    pins_in[3] = 1'b1;
    repeat (3) @(negedge clk);
    pins_in[3] = 1'b0;
    wait_cycles(10);
    reg_chk("glitch3_level", 3'b100, 32'h0001);
    reg_chk("glitch3_pend", 3'b011, 32'h0);
    @(negedge clk);
    pins_in[3] = 1'b1;
    repeat (6) @(negedge clk);
    pins_in[3] = 1'b0;
    wait_cycles(10);
    reg_chk("pulse6_pend", 3'b011, 32'h0008);
    reg_chk("pulse6_level", 3'b100, 32'h0001);
    reg_wr(3'b011, 32'hFFFF);

    // W1C: build pend = 0081 from a pin7 rise and a pin0 fall
    reg_wr(3'b001, 32'h0080);
    reg_wr(3'b010, 32'h0001);
    @(negedge clk);
    pins_in[7] = 1'b1;
    pins_in[0] = 1'b0;
    wait_cycles(10);
    reg_chk("w1c_setup", 3'b011, 32'h0081);
    reg_wr(3'b011, 32'h0001);
    reg_chk("w1c_bit0", 3'b011, 32'h0080);
    reg_wr(3'b011, 32'h0000);
    reg_chk("w1c_zero", 3'b011, 32'h0080);
    reg_wr(3'b011, 32'hFFFF);
    reg_chk("w1c_all", 3'b011, 32'h0);

    // set vs clear collision on pin 5 falling edge
    reg_wr(3'b010, 32'h0020);
    @(negedge clk);
    pins_in[5] = 1'b1;
    wait_cycles(10);
    reg_chk("coll_pre_pend", 3'b011, 32'h0);
    @(negedge clk);
    pins_in[5] = 1'b0;
    regSel = 3'b011;
    repeat (5) @(posedge clk);
    #1;
    check_vec("coll_pend_n4", dout, 32'h0);
    @(negedge clk);
    regSel = 3'b011;
    di     = 32'h0020;
    we     = 1'b1;
    @(posedge clk);
    #1;
    we = 1'b0;
    di = 32'd0;
    check_vec("coll_set_wins", dout, 32'h0020);
    reg_wr(3'b011, 32'h0020);
    reg_chk("coll_cleared", 3'b011, 32'h0);

    // masking
    reg_wr(3'b001, 32'h0100);
    @(negedge clk);
    pins_in[8] = 1'b1;
    wait_cycles(10);
    reg_chk("mask_pend", 3'b011, 32'h0100);
    check_vec("mask_irq_off", {31'd0, irq}, 32'h0);
    reg_wr(3'b000, 32'h0100);
    check_vec("mask_irq_on", {31'd0, irq}, 32'h1);
    reg_wr(3'b100, 32'hFFFF_FFFF);
    reg_wr(3'b111, 32'hFFFF_FFFF);
    reg_chk("ro_level", 3'b100, 32'h0000_0180);
    reg_chk("ro_en", 3'b000, 32'h0000_0100);
    reg_chk("ro_rise", 3'b001, 32'h0000_0100);
    reg_chk("ro_fall", 3'b010, 32'h0000_0020);
    reg_chk("ro_pend", 3'b011, 32'h0000_0100);
    reg_chk("ro_sel7", 3'b111, 32'h0);
    check_vec("ro_irq", {31'd0, irq}, 32'h1);
    check_vec("level_port", {16'd0, level}, 32'h0000_0180);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
